// File: rtl/seg_cube_ctrl.sv
// Eight-digit multiplexed seven-segment controller.
// CPU store port on one side, active-low segment/digit bus on the other.
module seg_cube_ctrl #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ioWrite,
  input  logic        CUBECtrl,
  input  logic [1:0]  addr,
  input  logic [31:0] write_data,
  output logic [7:0]  seg_out,
  output logic [7:0]  seg_en
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [15:0]   data_lo;
  logic [15:0]   data_hi;
  logic [7:0]    en_mask;
  logic [7:0]    dp_mask;

  logic          wr;
  logic          unused_hi;
  logic [31:0]   digits;
  logic [3:0]    nib;
  logic          lit;
  logic          dp_on;
  logic [6:0]    hex;
  logic [7:0]    en_nxt;
  logic [7:0]    seg_nxt;

  assign wr        = ioWrite & CUBECtrl;
  assign unused_hi = ^write_data[31:16];
  assign digits    = {data_hi, data_lo};
  assign nib       = digits[{idx, 2'b00} +: 4];
  assign lit       = en_mask[idx];
  assign dp_on     = dp_mask[idx];

  always_comb begin
    hex = 7'h7F;
    case (nib)
      4'h0: hex = 7'h40;
      4'h1: hex = 7'h79;
      4'h2: hex = 7'h24;
      4'h3: hex = 7'h30;
      4'h4: hex = 7'h19;
      4'h5: hex = 7'h12;
      4'h6: hex = 7'h02;
      4'h7: hex = 7'h78;
      4'h8: hex = 7'h00;
      4'h9: hex = 7'h10;
      4'hA: hex = 7'h08;
      4'hB: hex = 7'h03;
      4'hC: hex = 7'h46;
      4'hD: hex = 7'h21;
      4'hE: hex = 7'h06;
      4'hF: hex = 7'h0E;
      default: hex = 7'h7F;
    endcase
  end

  // Blanked digits drive both buses fully inactive, dp included.
  always_comb begin
    en_nxt  = 8'hFF;
    seg_nxt = 8'hFF;
    if (lit) begin
      en_nxt  = ~(8'b1 << idx);
      seg_nxt = {~dp_on, hex};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      idx <= 3'd0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
      idx <= idx + 3'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_lo <= 16'h0000;
      data_hi <= 16'h0000;
      en_mask <= 8'hFF;
      dp_mask <= 8'h00;
    end else if (wr) begin
      case (addr)
        2'b00: data_lo <= write_data[15:0];
        2'b01: data_hi <= write_data[15:0];
        2'b10: begin
          en_mask <= write_data[7:0];
          dp_mask <= write_data[15:8];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      seg_en  <= 8'hFF;
      seg_out <= 8'hFF;
    end else begin
      seg_en  <= en_nxt;
      seg_out <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_seg_cube_ctrl.sv
// Directed bench for seg_cube_ctrl with a 4-cycle digit slot.
// Expected digit/segment values are hand-derived per scenario.
module tb_seg_cube_ctrl;

  logic        clock;
  logic        reset_n;
  logic        ioWrite;
  logic        CUBECtrl;
  logic [1:0]  addr;
  logic [31:0] write_data;
  logic [7:0]  seg_out;
  logic [7:0]  seg_en;

  int checks;
  int errors;
  int ecount;

  localparam logic [7:0] FULL_SEG [0:7] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  seg_cube_ctrl #(.SCAN_DIV(4)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .ioWrite    (ioWrite),
    .CUBECtrl   (CUBECtrl),
    .addr       (addr),
    .write_data (write_data),
    .seg_out    (seg_out),
    .seg_en     (seg_en)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    @(negedge clock);
    ecount++;
  endtask

  function automatic int cur_digit();
    return ((ecount - 1) / 4) % 8;
  endfunction

  function automatic logic [7:0] en_of(int d);
    logic [7:0] one;
    one = 8'd1;
    return ~(one << d);
  endfunction

  task automatic cpu_write(input logic [1:0] a, input logic [15:0] d);
    ioWrite    = 1'b1;
    CUBECtrl   = 1'b1;
    addr       = a;
    write_data = {16'hDEAD, d};
    step();
    ioWrite    = 1'b0;
    CUBECtrl   = 1'b0;
    write_data = 32'h0;
    addr       = 2'b00;
  endtask

  task automatic check_mask_frame(input string tag);
    logic [7:0] ee;
    logic [7:0] es;
    int d;
    for (int i = 0; i < 32; i++) begin
      step();
      d = cur_digit();
      ee = 8'hFF;
      es = 8'hFF;
      if (d == 0) begin ee = 8'hFE; es = 8'h40; end
      if (d == 2) begin ee = 8'hFB; es = 8'hA4; end
      checks++;
      if (seg_en !== ee || seg_out !== es) begin
        errors++;
        $display("FAIL %s d%0d: seg_en=%h seg_out=%h want %h %h",
                 tag, d, seg_en, seg_out, ee, es);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    checks++;
    if (seg_en !== 8'hFF || seg_out !== 8'hFF) begin
      errors++;
      $display("FAIL reset_state: %h %h want FF FF", seg_en, seg_out);
    end
    @(negedge clock);
    reset_n = 1'b1;
    ecount = 0;
    step();
    checks++;
    if (seg_en !== 8'hFE || seg_out !== 8'hC0) begin
      errors++;
      $display("FAIL first_edge: %h %h want FE C0", seg_en, seg_out);
    end
    for (int i = 0; i < 39; i++) begin
      step();
      checks++;
      if (seg_en !== en_of(cur_digit()) || seg_out !== 8'hC0) begin
        errors++;
        $display("FAIL idle_scan e%0d: %h %h want %h C0",
                 ecount, seg_en, seg_out, en_of(cur_digit()));
      end
    end
  endtask

  task automatic test_full_write();
    int d;
    cpu_write(2'b00, 16'h3210);
    cpu_write(2'b01, 16'hFEDC);
    for (int i = 0; i < 32; i++) begin
      step();
      d = cur_digit();
      checks++;
      if (seg_en !== en_of(d) || seg_out !== FULL_SEG[d]) begin
        errors++;
        $display("FAIL full_write d%0d: %h %h want %h %h",
                 d, seg_en, seg_out, en_of(d), FULL_SEG[d]);
      end
    end
  endtask

  task automatic test_mask_dp();
    cpu_write(2'b10, 16'h0105);
    check_mask_frame("mask_dp");
  endtask

  task automatic test_ignored();
    ioWrite = 1'b1; CUBECtrl = 1'b0;
    addr = 2'b00; write_data = 32'h0000FFFF;
    step();
    ioWrite = 1'b0; write_data = 32'h0;
    check_mask_frame("ign_nocs");
    CUBECtrl = 1'b1; ioWrite = 1'b0;
    addr = 2'b10; write_data = 32'h000000FF;
    step();
    CUBECtrl = 1'b0; write_data = 32'h0; addr = 2'b00;
    check_mask_frame("ign_nowr");
    cpu_write(2'b11, 16'hFFFF);
    check_mask_frame("ign_addr3");
  endtask

  task automatic test_live_write();
    int n;
    cpu_write(2'b10, 16'h00FF);
    n = 0;
    while (!(cur_digit() == 0 && ((ecount - 1) % 4) == 0) && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL live_sync: no digit0 slot start");
    end
    checks++;
    if (seg_en !== 8'hFE || seg_out !== 8'hC0) begin
      errors++;
      $display("FAIL live_before: %h %h want FE C0", seg_en, seg_out);
    end
    cpu_write(2'b00, 16'h3218);
    checks++;
    if (seg_en !== 8'hFE || seg_out !== 8'hC0) begin
      errors++;
      $display("FAIL live_write_edge: %h %h want FE C0", seg_en, seg_out);
    end
    step();
    checks++;
    if (seg_en !== 8'hFE || seg_out !== 8'h80) begin
      errors++;
      $display("FAIL live_after: %h %h want FE 80", seg_en, seg_out);
    end
  endtask

  task automatic test_async_reset();
    int n;
    n = 0;
    while (!(cur_digit() == 5 && ((ecount - 1) % 4) == 1) && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (n >= 40 || seg_en !== 8'hDF) begin
      errors++;
      $display("FAIL arst_sync: seg_en=%h want DF", seg_en);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (seg_en !== 8'hFF || seg_out !== 8'hFF) begin
      errors++;
      $display("FAIL arst_immediate: %h %h want FF FF", seg_en, seg_out);
    end
    ioWrite = 1'b1; CUBECtrl = 1'b1;
    addr = 2'b00; write_data = 32'h00000005;
    @(posedge clock);
    @(negedge clock);
    ioWrite = 1'b0; CUBECtrl = 1'b0; write_data = 32'h0;
    reset_n = 1'b1;
    ecount = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      checks++;
      if (seg_en !== en_of(cur_digit()) || seg_out !== 8'hC0) begin
        errors++;
        $display("FAIL arst_restart e%0d: %h %h want %h C0",
                 ecount, seg_en, seg_out, en_of(cur_digit()));
      end
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    ecount     = 0;
    reset_n    = 1'b0;
    ioWrite    = 1'b0;
    CUBECtrl   = 1'b0;
    addr       = 2'b00;
    write_data = 32'h0;
    test_reset();
    test_full_write();
    test_mask_dp();
    test_ignored();
    test_live_write();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_cube_ctrl.md
# seg_cube_ctrl

Memory-mapped 8-digit seven-segment ("cube") display controller sitting directly downstream of the memory/IO steering block. It captures CPU store data when the cube chip-select and IO-write strobe are both high, and holds eight hex nibbles plus control bits in registers. It time-multiplexes the digits onto a shared active-low segment bus with a free-running scan counter. Write-only from the CPU side; no readback path.

## Interface
Parameters:
- SCAN_DIV, 100000, clock cycles each digit stays lit; legal range ≥ 1.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ioWrite  in  1  IO write strobe from the control unit.
- CUBECtrl  in  1  cube chip select, active high.
- addr  in  2  word select, driven from address bits [2:1] of the IO address.
- write_data  in  32  store data from the memory/IO steering block; only bits [15:0] are used.
- seg_out  out  8  segment bus, active low, bit order {dp,g,f,e,d,c,b,a}.
- seg_en  out  8  digit enables, active low; bit i selects digit i.

## Operation
- Write accept: when ioWrite=1 and CUBECtrl=1 at a rising edge, the register chosen by addr loads write_data[15:0].
  - addr=00: data_lo, which holds digits 3..0 (digit 0 = bits [3:0]).
  - addr=01: data_hi, which holds digits 7..4.
  - addr=10: ctrl. Bits [7:0] are en_mask (1 = digit lit); bits [15:8] are dp_mask (1 = decimal point on).
  - addr=11: no register changes.
- Scan counter cnt:
  - Counts 0..SCAN_DIV-1.
  - On the edge where cnt=SCAN_DIV-1, cnt returns to 0 and the digit index idx (3 bits) increments, wrapping 7→0.
  - With SCAN_DIV=1, idx advances on every edge.
- Output registers: at each edge, seg_en and seg_out load values computed from the pre-edge idx, data_lo, data_hi and ctrl.
  - If en_mask[idx]=1: seg_en gets only bit idx low, and seg_out[6:0] = hex decode of nibble idx.
  - seg_out[7] = ~dp_mask[idx].
  - If en_mask[idx]=0: seg_en = 8'hFF and seg_out = 8'hFF.
- Hex decode of seg_out[6:0] (active low):
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78
  - 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E
- Reset (asynchronous, while reset_n=0):
  - data_lo=0, data_hi=0.
  - en_mask=8'hFF, dp_mask=8'h00.
  - cnt=0, idx=0.
  - seg_en=8'hFF, seg_out=8'hFF.

## Timing
- Write latency: a write at edge k updates the register at edge k. seg_out/seg_en reflect the new value at edge k+1, provided idx at that point selects the affected digit.
- A write coinciding with an idx advance: the register update and the advance both occur at edge k. The output at edge k+1 uses the new idx and the new data.
- Output lags idx by one cycle. Digit d is driven for exactly SCAN_DIV consecutive cycles per frame, and a frame is 8·SCAN_DIV cycles.
- First lit output: at the first rising edge after reset_n deasserts, seg_en=8'hFE and seg_out=8'hC0 (digit 0 shows "0", dp off).
- Reset asserted mid-scan or mid-write: all state returns to reset values immediately, independent of clock. A write strobed in the same cycle reset_n is low is lost.
- A strobe with CUBECtrl=0, or with ioWrite=0, never changes any register.
- There is no glitch requirement beyond outputs being registered.

## Test plan
All scenarios use SCAN_DIV=4.
- Reset then idle: release reset_n and run 40 cycles.
  - First edge gives seg_en=FE, seg_out=C0.
  - seg_en steps FE→FD→FB…→7F, each held 4 cycles, then wraps to FE.
  - seg_out stays C0 throughout.
- Full write: write data_lo=16'h3210, then data_hi=16'hFEDC.
  - Over one frame, digits 0..7 show 40,79,24,30,46,21,06,0E (all with dp off, so bit 7 set).
  - Exact values: C0,F9,A4,B0,C6,A1,86,8E.
- Mask/dp: write ctrl=16'h0105.
  - Digits 1,3,4,5,6,7 give seg_en=FF and seg_out=FF.
  - Digit 0 shows dp on: seg_out bit 7 = 0.
  - Digit 2 is lit with dp off.
- Ignored writes:
  - Strobe ioWrite=1 with CUBECtrl=0 and data=FFFF: no register change.
  - Strobe CUBECtrl=1 with ioWrite=0: no register change.
  - Strobe both with addr=11: no register change.
  - Display stays identical across a full frame in each case.
- Write during the live digit: while digit 0 is displayed, write data_lo low nibble=8.
  - seg_out changes to 80 exactly one edge after the write edge.
  - The change happens within the same 4-cycle slot.
- Async reset mid-frame: pull reset_n low between edges while idx=5.
  - seg_en=FF and seg_out=FF immediately.
  - After release, the sequence restarts at digit 0 with cleared data and en_mask=FF.
